// File: rtl/floor_ctrl_pkg.sv
// floor_ctrl_pkg: shared state, action and mode encodings for the floor access sequencer
package floor_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, WAIT_ALT, COMMIT, DENY} state_t;
  typedef enum logic [1:0] {ACT_NONE, ACT_ALT, ACT_CHOSEN, ACT_EXIT} act_t;
  typedef enum logic [1:0] {MODE_ENTER, MODE_EXIT, MODE_RESTRICT} mode_t;
endpackage

// File: rtl/capacity_counter.sv
// capacity_counter: saturating up/down place counter that resets to its capacity
// Ports: CLK, RST_N (async active-low), inc/dec strobes, count (CNT_W bits, range 0..CAP)
module capacity_counter #(
  parameter int CNT_W = 3,
  parameter int CAP = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) count <= CNT_W'(CAP);
    else if (dec && count != '0) count <= count - 1'b1;
    else if (inc && count != CNT_W'(CAP)) count <= count + 1'b1;
endmodule

// File: rtl/floor_access_ctrl.sv
// floor_access_ctrl: badge request sequencer with per-floor capacity counters and alt-floor offer
// Ports: CLK, RST_N (async active-low); MODE/req/chosen_flr/id_valid/id_special/usr_flr badge inputs;
//   accept_alt/decline offer answers; action_taken/deny pulses, alt_offer/busy levels; remain_* counters.
// Option: FLOOR_CTRL_ALT_TIMEOUT_EN adds an ALT_TIMEOUT-cycle limit on waiting for an offer answer.
module floor_access_ctrl
  import floor_ctrl_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int CAP_SPEC_0 = 2,
  parameter int CAP_NORM_0 = 4,
  parameter int CAP_1 = 6,
  parameter int ALT_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       MODE,
  input  logic             req,
  input  logic             chosen_flr,
  input  logic             id_valid,
  input  logic             id_special,
  input  logic             usr_flr,
  input  logic             accept_alt,
  input  logic             decline,
  output logic [1:0]       action_taken,
  output logic             deny,
  output logic             alt_offer,
  output logic             busy,
  output logic [CNT_W-1:0] remain_flr_spec_0,
  output logic [CNT_W-1:0] remain_flr_norm_0,
  output logic [CNT_W-1:0] remain_flr_1
);
  state_t state, state_n;
  act_t act_q, act_n;
  logic exit_q, chosen_q, valid_q, special_q, usr_q, restrict_q;
  logic take, commit, chosen_nz, alt_nz, tmo;
  logic dec_spec, inc_spec, dec_norm, inc_norm, dec_f1, inc_f1;
  assign take = state == IDLE && req && !MODE[1];
  assign commit = state == COMMIT;
  assign chosen_nz = chosen_q ? |remain_flr_1 : |remain_flr_norm_0;
  assign alt_nz = chosen_q ? |remain_flr_norm_0 : |remain_flr_1;
`ifdef FLOOR_CTRL_ALT_TIMEOUT_EN
  localparam int TW = $clog2(ALT_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) tmo_cnt <= '0;
    else tmo_cnt <= state == WAIT_ALT ? tmo_cnt + 1'b1 : '0;
  assign tmo = tmo_cnt == TW'(ALT_TIMEOUT - 1);
`else
  logic unused_tmo;
  assign unused_tmo = |ALT_TIMEOUT;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    act_n = act_q;
    case (state)
      IDLE: state_n = take ? EVAL : IDLE;
      EVAL:
        if (exit_q) begin
          state_n = special_q || valid_q ? COMMIT : DENY;
          act_n = ACT_EXIT;
        end else if (special_q) begin
          state_n = |remain_flr_spec_0 ? COMMIT : DENY;
          act_n = ACT_CHOSEN;
        end else if (!valid_q) state_n = DENY;
        else if (chosen_nz) begin
          state_n = COMMIT;
          act_n = ACT_CHOSEN;
        end else state_n = alt_nz ? WAIT_ALT : DENY;
      WAIT_ALT:
        if (decline || tmo) state_n = DENY;
        else if (accept_alt) begin
          state_n = COMMIT;
          act_n = ACT_ALT;
        end
      default: state_n = IDLE;
    endcase
  end
  // Special IDs always use the floor-0 special pool; alt is the floor opposite the chosen one.
  assign dec_spec = commit && special_q && act_q == ACT_CHOSEN;
  assign inc_spec = commit && special_q && act_q == ACT_EXIT;
  assign dec_norm = commit && !special_q && ((act_q == ACT_CHOSEN && !chosen_q) || (act_q == ACT_ALT && chosen_q));
  assign dec_f1 = commit && !special_q && ((act_q == ACT_CHOSEN && chosen_q) || (act_q == ACT_ALT && !chosen_q));
  assign inc_norm = commit && !special_q && act_q == ACT_EXIT && !usr_q;
  assign inc_f1 = commit && !special_q && act_q == ACT_EXIT && usr_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      act_q <= ACT_NONE;
      {exit_q, chosen_q, valid_q, special_q, usr_q, restrict_q} <= '0;
      action_taken <= ACT_NONE;
      {deny, alt_offer, busy} <= '0;
    end else begin
      state <= state_n;
      act_q <= act_n;
      if (take) {exit_q, chosen_q, valid_q, special_q, usr_q} <= {MODE[0], chosen_flr, id_valid, id_special, usr_flr};
      restrict_q <= state == IDLE && req && MODE[1];
      action_taken <= commit ? act_q : ACT_NONE;
      deny <= state == DENY || restrict_q;
      alt_offer <= state_n == WAIT_ALT;
      busy <= state_n != IDLE;
    end
  capacity_counter #(.CNT_W(CNT_W), .CAP(CAP_SPEC_0)) u_spec_0 (
    .CLK(CLK), .RST_N(RST_N), .inc(inc_spec), .dec(dec_spec), .count(remain_flr_spec_0));
  capacity_counter #(.CNT_W(CNT_W), .CAP(CAP_NORM_0)) u_norm_0 (
    .CLK(CLK), .RST_N(RST_N), .inc(inc_norm), .dec(dec_norm), .count(remain_flr_norm_0));
  capacity_counter #(.CNT_W(CNT_W), .CAP(CAP_1)) u_flr_1 (
    .CLK(CLK), .RST_N(RST_N), .inc(inc_f1), .dec(dec_f1), .count(remain_flr_1));
endmodule

// File: tb/tb_floor_access_ctrl.sv
// tb_floor_access_ctrl: directed self-checking bench for floor_access_ctrl
module tb_floor_access_ctrl;
  logic CLK = 1'b0, RST_N = 1'b0, req = 1'b0, chosen_flr = 1'b0, id_valid = 1'b0;
  logic id_special = 1'b0, usr_flr = 1'b0, accept_alt = 1'b0, decline = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [1:0] action_taken;
  logic deny, alt_offer, busy;
  logic [2:0] remain_flr_spec_0, remain_flr_norm_0, remain_flr_1;
  int n_cmp = 0, n_bad = 0;
  floor_access_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .req(req), .chosen_flr(chosen_flr),
    .id_valid(id_valid), .id_special(id_special), .usr_flr(usr_flr),
    .accept_alt(accept_alt), .decline(decline), .action_taken(action_taken),
    .deny(deny), .alt_offer(alt_offer), .busy(busy),
    .remain_flr_spec_0(remain_flr_spec_0), .remain_flr_norm_0(remain_flr_norm_0),
    .remain_flr_1(remain_flr_1));
  always #5 CLK = ~CLK;
  task automatic issue(input logic [1:0] m, input logic c, v, s, u);
    @(negedge CLK);
    {MODE, chosen_flr, id_valid, id_special, usr_flr} = {m, c, v, s, u};
    req = 1'b1;
    @(negedge CLK);
    req = 1'b0;
  endtask
  task automatic run_req(input logic [1:0] m, input logic c, v, s, u);
    issue(m, c, v, s, u);
    repeat (2) @(negedge CLK);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge CLK);
    n_cmp++; if (action_taken !== 2'd0) begin n_bad++; $display("FAIL reset_action got %0d want 0", action_taken); end
    n_cmp++; if ({deny, alt_offer, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {deny, alt_offer, busy}); end
    n_cmp++; if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== {3'd2, 3'd4, 3'd6}) begin n_bad++; $display("FAIL reset_counters got %0d/%0d/%0d want 2/4/6", remain_flr_spec_0, remain_flr_norm_0, remain_flr_1); end
    RST_N = 1'b1;
  endtask
  task automatic test_enter_chosen;
    issue(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL enter_busy got %b want 1", busy); end
    @(negedge CLK);
    n_cmp++; if (action_taken !== 2'd0) begin n_bad++; $display("FAIL enter_early got %0d want 0", action_taken); end
    @(negedge CLK);
    n_cmp++; if (action_taken !== 2'd2) begin n_bad++; $display("FAIL enter_action got %0d want 2", action_taken); end
    n_cmp++; if (remain_flr_1 !== 3'd5) begin n_bad++; $display("FAIL enter_flr1 got %0d want 5", remain_flr_1); end
    @(negedge CLK);
    n_cmp++; if ({action_taken, busy} !== 3'b000) begin n_bad++; $display("FAIL enter_after got %b want 000", {action_taken, busy}); end
  endtask
  task automatic test_fill;
    for (int i = 0; i < 4; i++) run_req(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) run_req(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({remain_flr_norm_0, remain_flr_1} !== {3'd0, 3'd3}) begin n_bad++; $display("FAIL fill got %0d/%0d want 0/3", remain_flr_norm_0, remain_flr_1); end
  endtask
  task automatic test_alt_accept;
    issue(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if ({alt_offer, busy, action_taken} !== 4'b1100) begin n_bad++; $display("FAIL alt_offer got %b want 1100", {alt_offer, busy, action_taken}); end
    accept_alt = 1'b1;
    @(negedge CLK);
    accept_alt = 1'b0;
    n_cmp++; if (alt_offer !== 1'b0) begin n_bad++; $display("FAIL alt_drop got %b want 0", alt_offer); end
    @(negedge CLK);
    n_cmp++; if (action_taken !== 2'd1) begin n_bad++; $display("FAIL alt_action got %0d want 1", action_taken); end
    n_cmp++; if ({remain_flr_norm_0, remain_flr_1} !== {3'd0, 3'd2}) begin n_bad++; $display("FAIL alt_counters got %0d/%0d want 0/2", remain_flr_norm_0, remain_flr_1); end
  endtask
  task automatic test_alt_both;
    issue(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    {accept_alt, decline} = 2'b11;
    @(negedge CLK);
    {accept_alt, decline} = 2'b00;
    @(negedge CLK);
    n_cmp++; if ({deny, action_taken} !== 3'b100) begin n_bad++; $display("FAIL both_deny got %b want 100", {deny, action_taken}); end
    n_cmp++; if ({remain_flr_norm_0, remain_flr_1} !== {3'd0, 3'd2}) begin n_bad++; $display("FAIL both_counters got %0d/%0d want 0/2", remain_flr_norm_0, remain_flr_1); end
    @(negedge CLK);
    n_cmp++; if (deny !== 1'b0) begin n_bad++; $display("FAIL both_pulse got %b want 0", deny); end
  endtask
  task automatic test_special_exit;
    for (int i = 0; i < 2; i++) begin
      run_req(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (action_taken !== 2'd2) begin n_bad++; $display("FAIL spec_action%0d got %0d want 2", i, action_taken); end
    end
    run_req(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({deny, action_taken, remain_flr_spec_0} !== 6'b100000) begin n_bad++; $display("FAIL spec_full got %b want 100000", {deny, action_taken, remain_flr_spec_0}); end
    run_req(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({deny, action_taken} !== 3'b100) begin n_bad++; $display("FAIL no_id got %b want 100", {deny, action_taken}); end
    for (int i = 0; i < 4; i++) run_req(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (remain_flr_norm_0 !== 3'd4) begin n_bad++; $display("FAIL exit_refill got %0d want 4", remain_flr_norm_0); end
    run_req(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (action_taken !== 2'd3) begin n_bad++; $display("FAIL exit_action got %0d want 3", action_taken); end
    n_cmp++; if ({remain_flr_norm_0, remain_flr_1} !== {3'd4, 3'd2}) begin n_bad++; $display("FAIL exit_sat got %0d/%0d want 4/2", remain_flr_norm_0, remain_flr_1); end
  endtask
  task automatic test_restrict;
    issue(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({deny, busy} !== 2'b00) begin n_bad++; $display("FAIL restrict_early got %b want 00", {deny, busy}); end
    @(negedge CLK);
    n_cmp++; if ({deny, busy, action_taken} !== 4'b1000) begin n_bad++; $display("FAIL restrict_deny got %b want 1000", {deny, busy, action_taken}); end
    @(negedge CLK);
    n_cmp++; if (deny !== 1'b0) begin n_bad++; $display("FAIL restrict_pulse got %b want 0", deny); end
  endtask
  task automatic test_reset_wait_alt;
    for (int i = 0; i < 2; i++) run_req(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (alt_offer !== 1'b1) begin n_bad++; $display("FAIL rst_wait_offer got %b want 1", alt_offer); end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++; if ({alt_offer, busy, action_taken} !== 4'b0000) begin n_bad++; $display("FAIL rst_wait_flags got %b want 0000", {alt_offer, busy, action_taken}); end
    n_cmp++; if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== {3'd2, 3'd4, 3'd6}) begin n_bad++; $display("FAIL rst_wait_counters got %0d/%0d/%0d want 2/4/6", remain_flr_spec_0, remain_flr_norm_0, remain_flr_1); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({busy, action_taken, deny} !== 4'b0000) begin n_bad++; $display("FAIL rst_wait_after got %b want 0000", {busy, action_taken, deny}); end
  endtask
  task automatic test_timeout;
    logic seen_deny;
    for (int i = 0; i < 4; i++) run_req(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (alt_offer !== 1'b1) begin n_bad++; $display("FAIL tmo_offer got %b want 1", alt_offer); end
`ifdef FLOOR_CTRL_ALT_TIMEOUT_EN
    repeat (14) @(negedge CLK);
    n_cmp++; if ({alt_offer, deny} !== 2'b10) begin n_bad++; $display("FAIL tmo_before got %b want 10", {alt_offer, deny}); end
    @(negedge CLK);
    n_cmp++; if (alt_offer !== 1'b0) begin n_bad++; $display("FAIL tmo_drop got %b want 0", alt_offer); end
    @(negedge CLK);
    n_cmp++; if ({deny, remain_flr_1} !== {1'b1, 3'd6}) begin n_bad++; $display("FAIL tmo_deny got %b/%0d want 1/6", deny, remain_flr_1); end
`else
    seen_deny = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      seen_deny |= deny;
    end
    n_cmp++; if ({alt_offer, busy, seen_deny} !== 3'b110) begin n_bad++; $display("FAIL no_tmo got %b want 110", {alt_offer, busy, seen_deny}); end
    decline = 1'b1;
    @(negedge CLK);
    decline = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({deny, remain_flr_1} !== {1'b1, 3'd6}) begin n_bad++; $display("FAIL decline_deny got %b/%0d want 1/6", deny, remain_flr_1); end
`endif
  endtask
  initial begin
    test_reset;
    test_enter_chosen;
    test_fill;
    test_alt_accept;
    test_alt_both;
    test_special_exit;
    test_restrict;
    test_reset_wait_alt;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
